// File: rtl/fme_sad_if.sv
// Row-SAD input stream and best-candidate result bus of the fractional ME selector.
// The slave side is the selector; the master side is the upstream SAD stage / consumer.
interface fme_sad_if #(
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic [59:0]      sad_UH;
    logic [59:0]      sad_UQ;
    logic [59:0]      sad_M;
    logic [59:0]      sad_LQ;
    logic [59:0]      sad_LH;
    logic             out_valid;
    logic [4:0]       best_idx;
    logic [ACC_W-1:0] best_sad;

    modport master (
        output in_valid, in_first, sad_UH, sad_UQ, sad_M, sad_LQ, sad_LH,
        input  in_ready, out_valid, best_idx, best_sad
    );

    modport slave (
        input  in_valid, in_first, sad_UH, sad_UQ, sad_M, sad_LQ, sad_LH,
        output in_ready, out_valid, best_idx, best_sad
    );
endinterface

// File: rtl/fme_sad_select.sv
// Accumulates ROWS rows of 25 fractional SADs, then scans the totals and reports the minimum.
// Optional macro FME_CENTER_BIAS_EN: seed the scan with the centre candidate (12) so it wins ties.
module fme_sad_select #(
    parameter int ROWS  = 8,
    parameter int ACC_W = 16
) (
    input logic       clk,
    input logic       rst,
    fme_sad_if.slave  bus
);
    localparam int RCW = $clog2(ROWS + 1);
    localparam int SW  = ACC_W + 1;

    typedef enum logic {ACCUM, SELECT} state_t;

    state_t           state_q, state_d;
    logic [RCW-1:0]   row_cnt_q, row_cnt_d;
    logic [4:0]       scan_q, scan_d;
    logic [4:0]       run_idx_q, run_idx_d;
    logic [ACC_W-1:0] run_sad_q, run_sad_d;
    logic [4:0]       best_idx_q, best_idx_d;
    logic [ACC_W-1:0] best_sad_q, best_sad_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] acc_q [25];
    logic [ACC_W-1:0] acc_d [25];

    logic [299:0]     row_fields;
    logic             xfer;
    logic             clear_acc;
    logic [4:0]       cand;
    logic [ACC_W-1:0] cand_sad;
    logic             take;

    // Field k of the concatenation is candidate k = row*5 + col.
    assign row_fields = {bus.sad_LH, bus.sad_LQ, bus.sad_M, bus.sad_UQ, bus.sad_UH};
    assign xfer       = bus.in_valid && (state_q == ACCUM);
    assign clear_acc  = bus.in_first || (row_cnt_q == '0);

    generate
        for (genvar gi = 0; gi < 25; gi++) begin : g_acc
            logic [ACC_W-1:0] base;
            logic [ACC_W:0]   sum;
            assign base = clear_acc ? '0 : acc_q[gi];
            assign sum  = {1'b0, base} + SW'(row_fields[gi*12 +: 12]);
            assign acc_d[gi] = !xfer ? acc_q[gi]
                             : (sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0]);
        end
    endgenerate

    always_comb begin
        cand = scan_q;
`ifdef FME_CENTER_BIAS_EN
        // Step 0 seeds the centre, the rest walk 0..11, 13..24.
        if (scan_q == 5'd0) begin
            cand = 5'd12;
        end else if (scan_q <= 5'd12) begin
            cand = scan_q - 5'd1;
        end
`endif
    end

    assign cand_sad = acc_q[cand];
    assign take     = (scan_q == 5'd0) || (cand_sad < run_sad_q);

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        scan_d      = scan_q;
        run_idx_d   = run_idx_q;
        run_sad_d   = run_sad_q;
        best_idx_d  = best_idx_q;
        best_sad_d  = best_sad_q;
        out_valid_d = 1'b0;
        case (state_q)
            ACCUM: begin
                if (xfer) begin
                    row_cnt_d = bus.in_first ? RCW'(1) : row_cnt_q + RCW'(1);
                    if (row_cnt_d == RCW'(ROWS)) begin
                        state_d = SELECT;
                        scan_d  = 5'd0;
                    end
                end
            end
            SELECT: begin
                if (take) begin
                    run_idx_d = cand;
                    run_sad_d = cand_sad;
                end
                if (scan_q == 5'd24) begin
                    out_valid_d = 1'b1;
                    best_idx_d  = run_idx_d;
                    best_sad_d  = run_sad_d;
                    row_cnt_d   = '0;
                    state_d     = ACCUM;
                end else begin
                    scan_d = scan_q + 5'd1;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            row_cnt_q   <= '0;
            scan_q      <= '0;
            run_idx_q   <= '0;
            run_sad_q   <= '0;
            best_idx_q  <= '0;
            best_sad_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 25; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            scan_q      <= scan_d;
            run_idx_q   <= run_idx_d;
            run_sad_q   <= run_sad_d;
            best_idx_q  <= best_idx_d;
            best_sad_q  <= best_sad_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 25; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.best_idx  = best_idx_q;
    assign bus.best_sad  = best_sad_q;
endmodule

// File: tb/tb_fme_sad_select.sv
// Scoreboard bench for fme_sad_select: an 8-row instance for most scenarios, a 64-row one for saturation.
module tb_fme_sad_select;
`ifdef FME_CENTER_BIAS_EN
    localparam logic [4:0] TIE_IDX = 5'd12;
`else
    localparam logic [4:0] TIE_IDX = 5'd0;
`endif

    typedef struct {
        logic [4:0]  idx;
        logic [15:0] sad;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   last_xfer = 0;
    exp_t q8[$];
    exp_t q64[$];

    fme_sad_if #(.ACC_W(16)) if8 ();
    fme_sad_if #(.ACC_W(16)) if64 ();

    fme_sad_select #(.ROWS(8), .ACC_W(16)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    fme_sad_select #(.ROWS(64), .ACC_W(16)) dut64 (.clk(clk), .rst(rst), .bus(if64));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (if8.out_valid === 1'b1) begin
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out8 cyc=%0d idx=%0d sad=%0d", cyc, if8.best_idx, if8.best_sad);
            end else begin
                e = q8.pop_front();
                $display("result8 cyc=%0d idx=%0d sad=%0d", cyc, if8.best_idx, if8.best_sad);
                if (if8.best_idx !== e.idx || if8.best_sad !== e.sad || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL result8 got idx=%0d sad=%0d cyc=%0d expected idx=%0d sad=%0d cyc=%0d",
                             if8.best_idx, if8.best_sad, cyc, e.idx, e.sad, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if64.out_valid === 1'b1) begin
            checks++;
            if (q64.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out64 cyc=%0d idx=%0d sad=%0d", cyc, if64.best_idx, if64.best_sad);
            end else begin
                e = q64.pop_front();
                $display("result64 cyc=%0d idx=%0d sad=%0d", cyc, if64.best_idx, if64.best_sad);
                if (if64.best_idx !== e.idx || if64.best_sad !== e.sad || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL result64 got idx=%0d sad=%0d cyc=%0d expected idx=%0d sad=%0d cyc=%0d",
                             if64.best_idx, if64.best_sad, cyc, e.idx, e.sad, e.cyc);
                end
            end
        end
    end

    function automatic logic [299:0] fill(input logic [11:0] v);
        logic [299:0] r;
        for (int i = 0; i < 25; i++) r[i*12 +: 12] = v;
        return r;
    endfunction

    function automatic logic [299:0] rnd_row();
        logic [299:0] r;
        for (int i = 0; i < 25; i++) r[i*12 +: 12] = 12'($urandom_range(0, 4095));
        return r;
    endfunction

    function automatic logic rdy(input bit big);
        return big ? if64.in_ready : if8.in_ready;
    endfunction

    task automatic drive(input bit big, input logic [299:0] row, input logic first, input logic v);
        if (big) begin
            if64.in_valid = v;
            if64.in_first = first;
            {if64.sad_LH, if64.sad_LQ, if64.sad_M, if64.sad_UQ, if64.sad_UH} = row;
        end else begin
            if8.in_valid = v;
            if8.in_first = first;
            {if8.sad_LH, if8.sad_LQ, if8.sad_M, if8.sad_UQ, if8.sad_UH} = row;
        end
    endtask

    task automatic send_row(input bit big, input logic [299:0] row, input logic first);
        int w;
        w = 0;
        drive(big, row, first, 1'b1);
        while (rdy(big) !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 100) begin
            failures++;
            $display("FAIL send_timeout got in_ready=%b expected 1 within 100 cycles", rdy(big));
        end
        @(negedge clk);
        last_xfer = cyc;
        drive(big, row, 1'b0, 1'b0);
    endtask

    task automatic send_block(input bit big, input int n, input logic [299:0] row, input logic first);
        for (int i = 0; i < n; i++) send_row(big, row, first && (i == 0));
    endtask

    task automatic push(input bit big, input logic [4:0] idx, input logic [15:0] sad);
        exp_t e;
        e.idx = idx;
        e.sad = sad;
        e.cyc = last_xfer + 25;
        if (big) q64.push_back(e);
        else q8.push_back(e);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((q8.size() != 0 || q64.size() != 0) && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 200) begin
            failures++;
            $display("FAIL result_timeout got pending=%0d expected 0", q8.size() + q64.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks += 4;
        if (if8.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b expected 1", if8.in_ready); end
        if (if8.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b expected 0", if8.out_valid); end
        if (if8.best_idx !== 5'd0) begin failures++; $display("FAIL reset_best_idx got %0d expected 0", if8.best_idx); end
        if (if8.best_sad !== 16'd0) begin failures++; $display("FAIL reset_best_sad got %0d expected 0", if8.best_sad); end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_unique_min();
        logic [299:0] row;
        int low;
        row = fill(12'd1);
        row[18*12 +: 12] = 12'd0;
        send_block(1'b0, 8, row, 1'b1);
        push(1'b0, 5'd18, 16'd0);
        low = 0;
        while (if8.in_ready === 1'b0 && low < 100) begin
            low++;
            @(negedge clk);
        end
        checks++;
        if (low != 25) begin
            failures++;
            $display("FAIL ready_low_cycles got %0d expected 25", low);
        end
        wait_idle();
        $display("test_unique_min done");
    endtask

    task automatic test_ties();
        send_block(1'b0, 8, fill(12'd5), 1'b1);
        push(1'b0, TIE_IDX, 16'd40);
        wait_idle();
        $display("test_ties done");
    endtask

    task automatic test_saturation();
        logic [299:0] row;
        row = fill(12'd4095);
        row[11:0] = 12'd4094;
        send_block(1'b1, 64, row, 1'b1);
        push(1'b1, TIE_IDX, 16'd65535);
        wait_idle();
        $display("test_saturation done");
    endtask

    task automatic test_restart();
        logic [299:0] row;
        send_block(1'b0, 3, fill(12'd50), 1'b1);
        row = fill(12'd100);
        row[7*12 +: 12] = 12'd1;
        send_block(1'b0, 8, row, 1'b1);
        push(1'b0, 5'd7, 16'd8);
        wait_idle();
        $display("test_restart done");
    endtask

    task automatic test_first_on_complete();
        logic [299:0] row;
        send_block(1'b0, 7, fill(12'd9), 1'b1);
        row = fill(12'd2);
        row[3*12 +: 12] = 12'd1;
        send_row(1'b0, row, 1'b1);
        checks++;
        if (if8.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL first_restart_ready got %b expected 1", if8.in_ready);
        end
        send_block(1'b0, 7, row, 1'b0);
        push(1'b0, 5'd3, 16'd8);
        wait_idle();
        $display("test_first_on_complete done");
    endtask

    task automatic test_reset_select();
        logic [299:0] row;
        logic seen;
        send_block(1'b0, 8, fill(12'd3), 1'b1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 3;
        if (if8.in_ready !== 1'b1) begin failures++; $display("FAIL rst_sel_ready got %b expected 1", if8.in_ready); end
        if (dut8.acc_q[5] !== 16'd0) begin failures++; $display("FAIL rst_sel_acc got %0d expected 0", dut8.acc_q[5]); end
        if (if8.best_sad !== 16'd0) begin failures++; $display("FAIL rst_sel_best got %0d expected 0", if8.best_sad); end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (if8.out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rst_sel_no_result got out_valid=1 expected 0");
        end
        row = fill(12'd7);
        row[24*12 +: 12] = 12'd6;
        send_block(1'b0, 8, row, 1'b0);
        push(1'b0, 5'd24, 16'd48);
        wait_idle();
        $display("test_reset_select done");
    endtask

    task automatic test_back_to_back();
        logic [299:0] row;
        int w;
        row = fill(12'd3);
        row[20*12 +: 12] = 12'd2;
        send_block(1'b0, 8, row, 1'b1);
        push(1'b0, 5'd20, 16'd16);
        w = 0;
        while (if8.in_ready === 1'b0 && w < 100) begin
            drive(1'b0, rnd_row(), 1'($urandom_range(0, 1)), 1'b1);
            @(negedge clk);
            w++;
        end
        checks += 2;
        if (dut8.acc_q[20] !== 16'd16) begin failures++; $display("FAIL hold_acc20 got %0d expected 16", dut8.acc_q[20]); end
        if (dut8.acc_q[0] !== 16'd24) begin failures++; $display("FAIL hold_acc0 got %0d expected 24", dut8.acc_q[0]); end
        row = fill(12'd6);
        row[1*12 +: 12] = 12'd0;
        send_block(1'b0, 8, row, 1'b0);
        push(1'b0, 5'd1, 16'd0);
        wait_idle();
        $display("test_back_to_back done");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got time=%0t expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_unique_min();
        test_ties();
        test_saturation();
        test_restart();
        test_first_on_complete();
        test_reset_select();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
